// File: rtl/decoder_arm_ldm_seq_if.sv
// Bus bundle for the LDM/STM micro-op sequencer: instruction intake, base forwarding,
// micro-op issue and base writeback. DECODER_ARM_COND_EVAL_EN swaps cond_pass for cpsr_nzcv.
interface decoder_arm_ldm_seq_if #(
   parameter int FWD_CH = 2,
   parameter int ADDR_W = 32
);
   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
   // the offering side holds its payload stable while valid is high and ready is low.
   logic                     in_valid;
   logic                     in_ready;
   logic [31:0]              code;
`ifdef DECODER_ARM_COND_EVAL_EN
   logic [3:0]               cpsr_nzcv;
`else
   logic                     cond_pass;
`endif
   logic [ADDR_W-1:0]        base_data;
   logic [FWD_CH-1:0]        fwd_en;
   logic [5*FWD_CH-1:0]      fwd_id;
   logic [ADDR_W*FWD_CH-1:0] fwd_data;
   logic                     uop_valid;
   logic                     uop_ready;
   logic [ADDR_W-1:0]        uop_addr;
   logic [3:0]               uop_reg;
   logic                     uop_rd;
   logic                     uop_wr;
   logic                     uop_last;
   logic                     wb_en;
   logic [3:0]               wb_id;
   logic [ADDR_W-1:0]        wb_data;
   logic                     undef;

   modport slave (
`ifdef DECODER_ARM_COND_EVAL_EN
      input  cpsr_nzcv,
`else
      input  cond_pass,
`endif
      input  in_valid, code, base_data, fwd_en, fwd_id, fwd_data, uop_ready,
      output in_ready, uop_valid, uop_addr, uop_reg, uop_rd, uop_wr, uop_last,
      output wb_en, wb_id, wb_data, undef
   );

   modport master (
`ifdef DECODER_ARM_COND_EVAL_EN
      output cpsr_nzcv,
`else
      output cond_pass,
`endif
      output in_valid, code, base_data, fwd_en, fwd_id, fwd_data, uop_ready,
      input  in_ready, uop_valid, uop_addr, uop_reg, uop_rd, uop_wr, uop_last,
      input  wb_en, wb_id, wb_data, undef
   );
endinterface

// File: rtl/decoder_arm_ldm_seq.sv
// ARM LDM/STM sequencer: one register transfer per cycle plus optional base writeback.
// Define DECODER_ARM_COND_EVAL_EN to evaluate code[31:28] against cpsr_nzcv internally.
module decoder_arm_ldm_seq #(
   parameter int FWD_CH = 2,
   parameter int ADDR_W = 32
) (
   input logic                  clk,
   input logic                  rst,
   decoder_arm_ldm_seq_if.slave bus
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_r;
   logic [3:0]        reg_r;
   logic [15:0]       mask_r;
   logic [4:0]        cnt_r;
   logic              last_r;
   logic              l_r;
   logic              wb_pend;
   logic [ADDR_W-1:0] wb_r;
   logic [3:0]        rn_r;
   logic              undef_r;

   logic              is_block;
   logic              cond_ok;
   logic [3:0]        rn;
   logic [15:0]       list;
   logic [4:0]        n;
   logic [ADDR_W-1:0] base_sel;
   logic [ADDR_W-1:0] four_n;
   logic [ADDR_W-1:0] start;
   logic [ADDR_W-1:0] wb_next;
   logic              wb_allow;
   logic              wb_fire;

   function automatic logic [3:0] lowest_idx(input logic [15:0] m);
      lowest_idx = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (m[i]) lowest_idx = 4'(i);
   endfunction

`ifdef DECODER_ARM_COND_EVAL_EN
   function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
      logic nf, zf, cf, vf;
      {nf, zf, cf, vf} = f;
      case (c)
         4'h0:    eval_cond = zf;
         4'h1:    eval_cond = ~zf;
         4'h2:    eval_cond = cf;
         4'h3:    eval_cond = ~cf;
         4'h4:    eval_cond = nf;
         4'h5:    eval_cond = ~nf;
         4'h6:    eval_cond = vf;
         4'h7:    eval_cond = ~vf;
         4'h8:    eval_cond = cf & ~zf;
         4'h9:    eval_cond = ~cf | zf;
         4'hA:    eval_cond = (nf == vf);
         4'hB:    eval_cond = (nf != vf);
         4'hC:    eval_cond = ~zf & (nf == vf);
         4'hD:    eval_cond = zf | (nf != vf);
         4'hE:    eval_cond = 1'b1;
         default: eval_cond = 1'b0;
      endcase
   endfunction

   logic unused_bits;
   assign unused_bits = bus.code[22];
   assign cond_ok     = eval_cond(bus.code[31:28], bus.cpsr_nzcv);
`else
   logic unused_bits;
   assign unused_bits = ^{bus.code[31:28], bus.code[22]};
   assign cond_ok     = bus.cond_pass;
`endif

   always_comb begin
      is_block = (bus.code[27:25] == 3'b100);
      rn       = bus.code[19:16];
      list     = bus.code[15:0];
      n        = 5'd0;
      for (int i = 0; i < 16; i++)
         n = n + {4'd0, list[i]};
      // Descending scan so the lowest-index matching channel wins.
      base_sel = bus.base_data;
      for (int k = FWD_CH - 1; k >= 0; k--)
         if (bus.fwd_en[k] && bus.fwd_id[5*k +: 5] == {1'b0, rn})
            base_sel = bus.fwd_data[ADDR_W*k +: ADDR_W];
      four_n = ADDR_W'(n) << 2;
      case ({bus.code[24], bus.code[23]})
         2'b01:   start = base_sel;
         2'b11:   start = base_sel + ADDR_W'(4);
         2'b00:   start = base_sel - four_n + ADDR_W'(4);
         default: start = base_sel - four_n;
      endcase
      wb_next  = bus.code[23] ? base_sel + four_n : base_sel - four_n;
      wb_allow = bus.code[21] & ~(bus.code[20] & list[rn]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         addr_r  <= '0;
         reg_r   <= 4'd0;
         mask_r  <= 16'd0;
         cnt_r   <= 5'd0;
         last_r  <= 1'b0;
         l_r     <= 1'b0;
         wb_pend <= 1'b0;
         wb_r    <= '0;
         rn_r    <= 4'd0;
         undef_r <= 1'b0;
      end else begin
         undef_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  // A failed condition outranks decode rejection: the word is a silent no-op.
                  if (!cond_ok) begin
                  end else if (!is_block || rn == 4'd15) begin
                     undef_r <= 1'b1;
                  end else if (n != 5'd0) begin
                     state   <= ISSUE;
                     addr_r  <= start;
                     reg_r   <= lowest_idx(list);
                     mask_r  <= list & (list - 16'd1);
                     cnt_r   <= n;
                     last_r  <= (n == 5'd1);
                     l_r     <= bus.code[20];
                     wb_pend <= wb_allow;
                     wb_r    <= wb_next;
                     rn_r    <= rn;
                  end
               end
            end
            ISSUE: begin
               if (bus.uop_ready) begin
                  if (last_r) begin
                     state   <= IDLE;
                     addr_r  <= '0;
                     reg_r   <= 4'd0;
                     last_r  <= 1'b0;
                     wb_pend <= 1'b0;
                     cnt_r   <= 5'd0;
                  end else begin
                     addr_r <= addr_r + ADDR_W'(4);
                     reg_r  <= lowest_idx(mask_r);
                     mask_r <= mask_r & (mask_r - 16'd1);
                     cnt_r  <= cnt_r - 5'd1;
                     last_r <= (cnt_r == 5'd2);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign wb_fire      = (state == ISSUE) & last_r & wb_pend & bus.uop_ready;
   assign bus.in_ready = (state == IDLE);
   assign bus.uop_valid = (state == ISSUE);
   assign bus.uop_addr = addr_r;
   assign bus.uop_reg  = reg_r;
   assign bus.uop_last = last_r;
   assign bus.uop_rd   = (state == ISSUE) & l_r;
   assign bus.uop_wr   = (state == ISSUE) & ~l_r;
   assign bus.wb_en    = wb_fire;
   assign bus.wb_id    = wb_fire ? rn_r : 4'd0;
   assign bus.wb_data  = wb_fire ? wb_r : '0;
   assign bus.undef    = undef_r;

endmodule
